// File: rtl/ps2_rx_fifo_if.sv
// Downstream valid/ready port of the PS/2 receiver: one decoded scan code per entry.
interface ps2_rx_fifo_if;
    logic [7:0] code;
    logic       is_ext;
    logic       is_break;
    logic       valid;
    logic       ready;

    modport master (output code, is_ext, is_break, valid, input ready);
    modport slave  (input code, is_ext, is_break, valid, output ready);
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: sync + glitch filter, 11-bit frame FSM with timeout,
// E0/F0 prefix folding and a small first-word-fall-through FIFO with registered head.
module ps2_rx_fifo #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    ps2_rx_fifo_if.master out_if,
    output logic          frame_err,
    output logic          overflow,
    output logic          busy
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // ---------------- synchronisers and clock filter ----------------
    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q, fall_stb_q;
    logic [FW-1:0] fcnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
            fall_stb_q <= 1'b0;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
            fall_stb_q <= 1'b0;
            // Count consecutive samples disagreeing with the filtered level; any agreeing sample restarts the run.
            if (clk_s2_q != filt_q) begin
                if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                    filt_q     <= clk_s2_q;
                    fcnt_q     <= '0;
                    fall_stb_q <= ~clk_s2_q;
                end else begin
                    fcnt_q <= fcnt_q + 1'b1;
                end
            end else begin
                fcnt_q <= '0;
            end
        end
    end

    // ---------------- frame FSM ----------------
    state_t        state_q;
    logic [7:0]    shift_q;
    logic [2:0]    bitcnt_q;
    logic          par_q;
    logic [TW-1:0] tmo_q;
    logic          byte_stb_q, frame_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            byte_stb_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            byte_stb_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (fall_stb_q) begin
                // An edge always beats a coincident timeout.
                tmo_q <= '0;
                case (state_q)
                    IDLE: if (!dat_s2_q) begin
                        state_q  <= DATA;
                        bitcnt_q <= '0;
                    end
                    DATA: begin
                        shift_q  <= {dat_s2_q, shift_q[7:1]};
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == 3'd7) state_q <= PARITY;
                    end
                    PARITY: begin
                        par_q   <= dat_s2_q;
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (dat_s2_q && (^{shift_q, par_q})) byte_stb_q  <= 1'b1;
                        else                                 frame_err_q <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q == IDLE) begin
                tmo_q <= '0;
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_q     <= IDLE;
                frame_err_q <= 1'b1;
                tmo_q       <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    // ---------------- prefix folding and FIFO ----------------
    logic                        ext_q, brk_q, overflow_q, valid_q;
    logic [FIFO_DEPTH-1:0][9:0]  mem_q;
    logic [AW-1:0]               wr_q, rd_q, rd_d;
    logic [AW:0]                 cnt_q, cnt_d;
    logic [9:0]                  head_q, head_d, wdata;
    logic                        is_pfx, push, full, pop, do_push;

    always_comb begin
        is_pfx  = (shift_q == 8'hE0) || (shift_q == 8'hF0);
        push    = byte_stb_q && !is_pfx;
        wdata   = {ext_q, brk_q, shift_q};
        full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
        pop     = valid_q && out_if.ready;
        do_push = push && (!full || pop);
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(pop);
        rd_d    = pop ? rd_q + 1'b1 : rd_q;
        head_d  = head_q;
        // The new entry is not in mem_q yet, so route it straight to the head when it becomes the only entry.
        if (cnt_d != '0) begin
            if (do_push && (cnt_q == (AW+1)'(pop))) head_d = wdata;
            else                                    head_d = mem_q[rd_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            mem_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            head_q     <= '0;
        end else begin
            if (frame_err_q) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (byte_stb_q) begin
                if (shift_q == 8'hE0)      ext_q <= 1'b1;
                else if (shift_q == 8'hF0) brk_q <= 1'b1;
                else begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end
            end
            if (do_push) begin
                mem_q[wr_q] <= wdata;
                wr_q        <= wr_q + 1'b1;
            end
            overflow_q <= push && full && !pop;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            valid_q    <= (cnt_d != '0);
            head_q     <= head_d;
        end
    end

    assign out_if.code     = head_q[7:0];
    assign out_if.is_break = head_q[8];
    assign out_if.is_ext   = head_q[9];
    assign out_if.valid    = valid_q;
    assign frame_err       = frame_err_q;
    assign overflow        = overflow_q;
    assign busy            = (state_q != IDLE);
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Randomised PS/2 frame stimulus checked against a queue-based model of prefix folding and FIFO order.
module tb_ps2_rx_fifo;
    localparam int FL = 8, TO = 1000, DEPTH = 8;

    logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic frame_err, overflow, busy;
    ps2_rx_fifo_if rx_if ();

    ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .out_if(rx_if), .frame_err(frame_err), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: flags and expected FIFO contents in arrival order.
    logic [9:0] exp_q[$];
    bit m_ext, m_brk;
    int err_exp = 0, ovf_exp = 0, err_cnt = 0, ovf_cnt = 0, pop_cnt = 0;
    int cyc = 0, vld_rise_cyc = 0, vld_run = 0, max_vld_run = 0, stop_fall_cyc = 0;
    bit rnd_rdy = 0, prev_vld = 0;

    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            err_exp++;
            m_ext = 0; m_brk = 0;
        end else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0)     m_brk = 1;
        else begin
            if (exp_q.size() >= DEPTH) ovf_exp++;
            else exp_q.push_back({m_ext, m_brk, b});
            m_ext = 0; m_brk = 0;
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) if (rnd_rdy) begin
        #1 rx_if.ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) if (!rst) begin
        if (frame_err) err_cnt++;
        if (overflow)  ovf_cnt++;
        if (rx_if.valid && !prev_vld) vld_rise_cyc = cyc;
        vld_run = rx_if.valid ? vld_run + 1 : 0;
        if (vld_run > max_vld_run) max_vld_run = vld_run;
        prev_vld = rx_if.valid;
        if (rx_if.valid && rx_if.ready) begin
            if (exp_q.size() == 0) chk("spurious_pop", 1, 0);
            else begin
                chk("entry", {rx_if.is_ext, rx_if.is_break, rx_if.code}, exp_q.pop_front());
                pop_cnt++;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        wait_cyc(15);
        ps2_clk = 1'b0;
        stop_fall_cyc = cyc;
        wait_cyc(30);
        ps2_clk = 1'b1;
        wait_cyc(15);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        model_byte(b, !bad_par && !bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b ^ bad_par);
        ps2_bit(!bad_stop);
        ps2_data = 1'b1;
        wait_cyc(30);
    endtask

    initial begin
        int p0, any_busy;
        rx_if.ready = 1'b1;
        wait_cyc(3);
        chk("rst_valid", rx_if.valid, 0);
        chk("rst_outs", {rx_if.is_ext, rx_if.is_break, rx_if.code, frame_err, overflow, busy}, 0);
        @(negedge clk) rst = 1'b0;
        wait_cyc(5);

        // Single code, latency and single-cycle valid with ready held high.
        max_vld_run = 0;
        send_frame(8'h1C, 0, 0);
        chk("t1_latency", vld_rise_cyc - stop_fall_cyc, 12);
        chk("t1_vld_run", max_vld_run, 1);
        chk("t1_err", err_cnt, err_exp);
        chk("t1_drained", exp_q.size(), 0);

        // Prefix folding.
        p0 = pop_cnt;
        send_frame(8'hF0, 0, 0); send_frame(8'h1C, 0, 0);
        send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h75, 0, 0);
        chk("t2_pops", pop_cnt - p0, 2);

        // Parity error, stop error, then a clean code with flags clear.
        send_frame(8'hE0, 0, 0);
        send_frame(8'h1C, 1, 0);
        send_frame(8'h55, 0, 1);
        send_frame(8'h32, 0, 0);
        chk("t3_err", err_cnt, err_exp);
        chk("t3_drained", exp_q.size(), 0);

        // Timeout on a truncated frame.
        send_frame(8'hE0, 0, 0);
        model_byte(8'h00, 0);
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        wait_cyc(850);
        chk("t4_busy_mid", busy, 1);
        wait_cyc(200);
        chk("t4_busy_after", busy, 0);
        chk("t4_err", err_cnt, err_exp);
        send_frame(8'h74, 0, 0);
        chk("t4_drained", exp_q.size(), 0);

        // Overflow with the consumer stalled, then drain in order.
        rx_if.ready = 1'b0;
        p0 = pop_cnt;
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0);
        chk("t5_ovf", ovf_cnt, ovf_exp);
        chk("t5_ovf_one", ovf_exp, 1);
        chk("t5_valid_full", rx_if.valid, 1);
        rx_if.ready = 1'b1;
        wait_cyc(20);
        chk("t5_pops", pop_cnt - p0, 8);
        chk("t5_valid_empty", rx_if.valid, 0);

        // Short glitch while idle must not start a frame.
        any_busy = 0;
        ps2_clk = 1'b0; wait_cyc(3); ps2_clk = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) any_busy = 1;
        end
        chk("t6_glitch", any_busy, 0);

        // Reset during bit 4 of 0x5A; bit 4 is 1, so the restarted receiver stays idle.
        send_frame(8'h33, 0, 0);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'(8'h5A >> i));
        ps2_data = 1'b1;
        wait_cyc(15);
        ps2_clk = 1'b0;
        wait_cyc(20);
        chk("t6_busy_pre", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_outs", {rx_if.valid, rx_if.is_ext, rx_if.is_break, rx_if.code, frame_err, overflow, busy}, 0);
        wait_cyc(2);
        rst = 1'b0;
        m_ext = 0; m_brk = 0;
        wait_cyc(10);
        ps2_clk = 1'b1;
        wait_cyc(1200);
        chk("t6_busy_end", busy, 0);
        chk("t6_valid_end", rx_if.valid, 0);
        chk("t6_err", err_cnt, err_exp);

        // Random codes, prefixes and parity errors with a random consumer.
        rnd_rdy = 1;
        for (int n = 0; n < 25; n++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 9);
            b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
            send_frame(b, $urandom_range(0, 7) == 0, 0);
        end
        rnd_rdy = 0;
        @(posedge clk) #1 rx_if.ready = 1'b1;
        wait_cyc(30);
        chk("rnd_drained", exp_q.size(), 0);
        chk("rnd_err", err_cnt, err_exp);
        chk("rnd_ovf", ovf_cnt, ovf_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- PS/2 device-to-host receiver that feeds the keyboard text-buffer stage.
- Synchronises and de-glitches ps2_clk/ps2_data, then deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop).
- Folds E0 (extended) and F0 (break) prefix bytes into flags on the following scan code.
- Buffers decoded codes in a small FIFO, presented downstream on a valid/ready interface.

Parameters:
- FILTER_LEN, 8, consecutive equal synchronised ps2_clk samples required to change the filtered clock level.
- TIMEOUT_CYCLES, 100000, clk cycles without a PS/2 falling edge before an in-progress frame is aborted (1 ms at 100 MHz).
- FIFO_DEPTH, 8, number of entries; power of two, minimum 2.

Ports:
- clk        input   1  system clock.
- rst        input   1  asynchronous, active-high reset.
- ps2_clk    input   1  raw PS/2 clock from the pin, asynchronous.
- ps2_data   input   1  raw PS/2 data from the pin, asynchronous.
- code       output  8  scan code at the FIFO head.
- is_ext     output  1  head code was preceded by E0.
- is_break   output  1  head code was preceded by F0.
- valid      output  1  FIFO non-empty; code, is_ext and is_break are meaningful.
- ready      input   1  consumer accepts the head entry this cycle.
- frame_err  output  1  one-cycle pulse on parity, stop or timeout error.
- overflow   output  1  one-cycle pulse when a code is dropped because the FIFO is full.
- busy       output  1  receiver FSM not in IDLE.

Behaviour:
- Reset:
  - All outputs 0; FIFO empty; FSM in IDLE; prefix flags clear.
  - Synchroniser and filter registers reset to 1 (bus idle level).
- Synchronisers: both inputs pass through 2 flip-flops.
- Clock filter:
  - Filtered clock goes 0 after FILTER_LEN consecutive synchronised 0 samples; goes 1 after FILTER_LEN consecutive 1 samples; otherwise holds.
  - fall_stb is a one-cycle strobe on each filtered 1->0 transition.
  - Data is sampled (synchronised ps2_data) in the fall_stb cycle.
- FSM states and transitions:
  - IDLE: on fall_stb with data=0, go to DATA with bit count 0. On fall_stb with data=1, ignore and stay in IDLE.
  - DATA: on each fall_stb, shift the bit in at the MSB end (LSB-first assembly). After the 8th bit, go to PARITY.
  - PARITY: on fall_stb, store the bit and go to STOP.
  - STOP: on fall_stb, return to IDLE. Frame is good iff stop=1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity).
  - Good frame: byte_stb asserts on the next cycle.
  - Bad frame: frame_err pulses on the next cycle and both prefix flags clear.
- Timeout:
  - Counter clears on every fall_stb and whenever in IDLE.
  - In any state other than IDLE, when the counter reaches TIMEOUT_CYCLES-1: return to IDLE, pulse frame_err, clear prefix flags, discard partial data.
- Prefix folding, applied on byte_stb:
  - Byte E0: set ext flag; nothing pushed.
  - Byte F0: set brk flag; nothing pushed.
  - Any other byte: push {ext, brk, byte} and clear both flags. This includes E1, AA and FA, which are pushed as plain codes.
- FIFO:
  - First-word-fall-through. valid = not empty; outputs show the head entry; pop when valid && ready.
  - Push to a full FIFO with no pop in the same cycle: entry dropped, overflow pulses, contents unchanged.
  - Push and pop in the same cycle when full: both succeed, count unchanged.
  - Push when empty: valid rises the following cycle; there is no same-cycle bypass.
  - Pointers wrap modulo FIFO_DEPTH; count is tracked with log2(FIFO_DEPTH)+1 bits.
  - code, is_ext and is_break hold the last head value while valid=0; downstream must not use them then.
- Latency:
  - fall_stb of the stop bit in cycle T, then byte_stb in T+1, then FIFO write at the end of T+1, then valid=1 in T+2.
  - Filter delay from the pin is 2+FILTER_LEN cycles.
- Reset mid-frame: the FSM, FIFO and flags clear immediately (asynchronous); the rest of the interrupted frame is rejected by start-bit, parity or timeout rules.
- Simultaneous events: a timeout and a fall_stb in the same cycle is resolved in favour of fall_stb.

Test Plan:
- Send frame 0x1C (parity 0) with ready=1: valid pulses one cycle in T+2; code=0x1C, is_ext=0, is_break=0; no frame_err.
- Send F0 then 1C, then E0 F0 75: the two FIFO entries are {0,1,1C} and {1,1,75}; no entry exists for E0 or F0.
- Send 0x1C with parity bit 1, then a frame with stop=0: frame_err pulses once per frame, nothing pushed; a following valid 0x32 is received with flags clear.
- Send E0, then start plus 5 data bits and stop toggling ps2_clk (TIMEOUT_CYCLES=1000): frame_err pulses about 1000 cycles after the last edge and busy drops. Next frame 0x74 arrives with is_ext=0.
- Hold ready=0 and send 9 codes 0x01..0x09 (FIFO_DEPTH=8): the 9th raises overflow for one cycle. Draining yields 01..08 in order, then valid=0.
- Apply a 3-cycle low glitch on ps2_clk while idle (FILTER_LEN=8): no fall_stb, busy stays 0. Then assert rst during bit 4 of a frame: all outputs 0 and the partial frame is discarded.
